// File: rtl/coh_chan_arb_buf.sv
// N-channel coherence message buffer: per-channel FIFOs merged onto one registered output port.
// Enqueue-to-output latency 1 cycle; in_ready depends only on FIFO occupancy, and multi-beat bursts lock the arbiter.
module coh_chan_arb_buf #(
    parameter int N_CH      = 3,
    parameter int MSG_W     = 64,
    parameter int DEPTH     = 4,
    parameter int PRIO_MODE = 0,
    parameter int CNT_W     = $clog2(DEPTH + 1),
    parameter int CH_W      = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic [N_CH*MSG_W-1:0]   in_data,
    input  logic [N_CH-1:0]         in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [MSG_W-1:0]        out_data,
    output logic                    out_last,
    output logic [CH_W-1:0]         out_ch,
    output logic [N_CH*CNT_W-1:0]   ch_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [MSG_W:0]     mem_q    [N_CH][DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [N_CH];
    logic [PTR_W-1:0]   wr_ptr_d [N_CH];
    logic [PTR_W-1:0]   rd_ptr_q [N_CH];
    logic [PTR_W-1:0]   rd_ptr_d [N_CH];
    logic [CNT_W-1:0]   cnt_q    [N_CH];
    logic [CNT_W-1:0]   cnt_d    [N_CH];

    logic [N_CH-1:0]    push;
    logic [N_CH-1:0]    pop;
    logic [N_CH-1:0]    nonempty;

    logic               gnt_vld;
    logic [CH_W-1:0]    gnt;
    logic [MSG_W:0]     head;
    logic               load;

    logic               out_valid_q, out_valid_d;
    logic [MSG_W-1:0]   out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [CH_W-1:0]    out_ch_q, out_ch_d;
    logic               lock_q, lock_d;
    logic [CH_W-1:0]    lock_ch_q, lock_ch_d;
    logic [CH_W-1:0]    ptr_q, ptr_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic int wrap_ch(input int v);
        return (v >= N_CH) ? v - N_CH : v;
    endfunction

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = (cnt_q[i] < CNT_W'(DEPTH)) & ~flush;
            push[i]     = in_valid[i] & in_ready[i];
            nonempty[i] = (cnt_q[i] != '0);
        end
    end

    // Scan in reverse so the last hit is the first channel in priority order.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        if (lock_q) begin
            gnt_vld = nonempty[lock_ch_q];
            gnt     = lock_ch_q;
        end else if (PRIO_MODE != 0) begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                if (nonempty[k]) begin
                    gnt_vld = 1'b1;
                    gnt     = CH_W'(k);
                end
            end
        end else begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                if (nonempty[wrap_ch(int'(ptr_q) + k)]) begin
                    gnt_vld = 1'b1;
                    gnt     = CH_W'(wrap_ch(int'(ptr_q) + k));
                end
            end
        end
    end

    assign head = mem_q[gnt][rd_ptr_q[gnt]];
    assign load = (~out_valid_q | out_ready) & gnt_vld & ~flush;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            pop[i] = load & (gnt == CH_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i];
            if (flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                cnt_d[i]    = '0;
            end else begin
                if (push[i]) wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
                if (pop[i])  rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
                if (push[i] && !pop[i]) cnt_d[i] = cnt_q[i] + 1'b1;
                if (pop[i] && !push[i]) cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
        ptr_d       = ptr_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
            out_ch_d    = '0;
            lock_d      = 1'b0;
            lock_ch_d   = '0;
            ptr_d       = '0;
        end else if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = head[MSG_W-1:0];
            out_last_d  = head[MSG_W];
            out_ch_d    = gnt;
            if (!head[MSG_W]) begin
                lock_d    = 1'b1;
                lock_ch_d = gnt;
            end else begin
                lock_d = 1'b0;
                // Pointer only moves at burst boundaries so a locked burst never skews fairness.
                if (PRIO_MODE == 0) ptr_d = CH_W'(wrap_ch(int'(gnt) + 1));
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
            ptr_q       <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= {in_last[i], in_data[i*MSG_W +: MSG_W]};
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_cnt
        assign ch_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_coh_chan_arb_buf.sv
// Directed bench: round-robin instance (dut) and fixed-priority instance (dut_p), both N_CH=3, DEPTH=4.
module tb_coh_chan_arb_buf;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         flush, out_ready, out_valid, out_last;
    logic [2:0]   in_valid, in_last, in_ready;
    logic [191:0] in_data;
    logic [63:0]  out_data;
    logic [1:0]   out_ch;
    logic [8:0]   ch_count;

    logic         flush_p, out_ready_p, out_valid_p, out_last_p;
    logic [2:0]   in_valid_p, in_last_p, in_ready_p;
    logic [191:0] in_data_p;
    logic [63:0]  out_data_p;
    logic [1:0]   out_ch_p;
    logic [8:0]   ch_count_p;

    int checks   = 0;
    int failures = 0;
    int idx;
    logic acc;

    coh_chan_arb_buf #(.N_CH(3), .MSG_W(64), .DEPTH(4), .PRIO_MODE(0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_ch(out_ch), .ch_count(ch_count)
    );

    coh_chan_arb_buf #(.N_CH(3), .MSG_W(64), .DEPTH(4), .PRIO_MODE(1)) dut_p (
        .clk(clk), .rst(rst), .flush(flush_p),
        .in_valid(in_valid_p), .in_ready(in_ready_p), .in_data(in_data_p), .in_last(in_last_p),
        .out_valid(out_valid_p), .out_ready(out_ready_p), .out_data(out_data_p),
        .out_last(out_last_p), .out_ch(out_ch_p), .ch_count(ch_count_p)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] cnt(input int i);
        return ch_count[i*3 +: 3];
    endfunction

    function automatic logic [2:0] cnt_p(input int i);
        return ch_count_p[i*3 +: 3];
    endfunction

    task automatic set_in(input int ch, input logic v, input logic [63:0] d, input logic l);
        in_valid[ch]        = v;
        in_data[ch*64 +: 64] = d;
        in_last[ch]         = l;
    endtask

    task automatic do_reset();
        in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        in_valid_p = '0; in_last_p = '0; in_data_p = '0; out_ready_p = 1'b0; flush_p = 1'b0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        flush = 1'b0; out_ready = 1'b0; in_valid = '0; in_last = '0; in_data = '0;
        flush_p = 1'b0; out_ready_p = 1'b0; in_valid_p = '0; in_last_p = '0; in_data_p = '0;

        // 1: reset state and single-beat latency
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_ch_count", ch_count, 0);
        #1 rst = 1'b1;
        #1 chk("rst_in_ready", in_ready, 3'b111);
        set_in(1, 1'b1, 64'hA5, 1'b1);
        out_ready = 1'b1;
        tick();
        in_valid = '0;
        chk("t1_cnt_after_enq", cnt(1), 1);
        chk("t1_valid_not_yet", out_valid, 0);
        tick();
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 64'hA5);
        chk("t1_ch", out_ch, 1);
        chk("t1_last", out_last, 1);
        chk("t1_cnt_after_pop", cnt(1), 0);
        tick();
        chk("t1_valid_drop", out_valid, 0);

        // 2: round-robin over preloaded channels
        do_reset();
        for (int c = 0; c < 3; c++) set_in(c, 1'b1, 64'h100 * c, 1'b1);
        tick();
        for (int c = 0; c < 3; c++) set_in(c, 1'b1, 64'h100 * c + 1, 1'b1);
        tick();
        in_valid = '0;
        out_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            if (s > 0) tick();
            chk("t2_rr_valid", out_valid, 1);
            chk("t2_rr_ch", out_ch, s % 3);
            chk("t2_rr_data", out_data, 64'h100 * (s % 3) + s / 3);
        end
        tick();
        chk("t2_rr_idle", out_valid, 0);

        // 3: burst lock with a late middle beat
        do_reset();
        out_ready = 1'b1;
        set_in(0, 1'b1, 64'hD0, 1'b0);
        set_in(2, 1'b1, 64'hE0, 1'b1);
        tick();
        in_valid = '0;
        tick();
        chk("t3_b0_ch", out_ch, 0);
        chk("t3_b0_data", out_data, 64'hD0);
        chk("t3_b0_last", out_last, 0);
        tick();
        chk("t3_gap1_valid", out_valid, 0);
        tick();
        chk("t3_gap2_valid", out_valid, 0);
        chk("t3_ch2_waiting", cnt(2), 1);
        set_in(0, 1'b1, 64'hD1, 1'b0);
        tick();
        chk("t3_gap3_valid", out_valid, 0);
        set_in(0, 1'b1, 64'hD2, 1'b1);
        tick();
        in_valid = '0;
        chk("t3_b1_ch", out_ch, 0);
        chk("t3_b1_data", out_data, 64'hD1);
        tick();
        chk("t3_b2_ch", out_ch, 0);
        chk("t3_b2_data", out_data, 64'hD2);
        chk("t3_b2_last", out_last, 1);
        tick();
        chk("t3_ch2_ch", out_ch, 2);
        chk("t3_ch2_data", out_data, 64'hE0);
        tick();
        chk("t3_idle", out_valid, 0);

        // 4: full FIFO under backpressure, then in-order drain
        do_reset();
        idx = 0;
        set_in(0, 1'b1, 64'hF0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            acc = in_valid[0] & in_ready[0];
            tick();
            if (acc) begin
                idx++;
                in_data[63:0] = 64'hF0 + idx;
            end
        end
        chk("t4_accepted", idx, 5);
        chk("t4_full_cnt", cnt(0), 4);
        chk("t4_full_rdy", in_ready[0], 0);
        chk("t4_hold_valid", out_valid, 1);
        chk("t4_hold_data", out_data, 64'hF0);
        tick();
        chk("t4_hold_data2", out_data, 64'hF0);
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            acc = in_valid[0] & in_ready[0];
            tick();
            if (acc) begin
                idx++;
                if (idx == 6) in_valid[0] = 1'b0;
            end
            chk("t4_drain_valid", out_valid, 1);
            chk("t4_drain_data", out_data, 64'hF0 + k);
        end
        tick();
        chk("t4_drain_idle", out_valid, 0);
        chk("t4_drain_cnt", cnt(0), 0);
        chk("t4_all_accepted", idx, 6);

        // 5: fixed priority, ch0 starves ch2 while non-empty
        do_reset();
        out_ready_p = 1'b1;
        in_valid_p = 3'b101;
        in_last_p = 3'b111;
        in_data_p[63:0] = 64'hC0;
        in_data_p[191:128] = 64'hE2;
        tick();
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t5_prio_ch0", out_ch_p, 0);
            chk("t5_prio_data0", out_data_p, 64'hC0);
        end
        chk("t5_ch2_full", cnt_p(2), 4);
        chk("t5_ch2_rdy", in_ready_p[2], 0);
        in_valid_p[0] = 1'b0;
        tick();
        chk("t5_last_ch0", out_ch_p, 0);
        tick();
        chk("t5_ch2_ch", out_ch_p, 2);
        chk("t5_ch2_data", out_data_p, 64'hE2);
        chk("t5_ch2_cnt", cnt_p(2), 3);
        in_valid_p = '0;

        // 6a: synchronous flush mid-burst
        do_reset();
        set_in(0, 1'b1, 64'hB0, 1'b0);
        tick();
        in_data[63:0] = 64'hB1;
        tick();
        in_data[63:0] = 64'hB2;
        tick();
        in_data[63:0] = 64'hB3;
        tick();
        in_valid = '0;
        chk("t6_pre_cnt", cnt(0), 3);
        chk("t6_pre_valid", out_valid, 1);
        flush = 1'b1;
        out_ready = 1'b1;
        set_in(1, 1'b1, 64'h11, 1'b1);
        #1;
        chk("t6_flush_rdy", in_ready, 0);
        tick();
        flush = 1'b0;
        chk("t6_flush_valid", out_valid, 0);
        chk("t6_flush_cnt", ch_count, 0);
        tick();
        in_valid = '0;
        tick();
        chk("t6_unlock_valid", out_valid, 1);
        chk("t6_unlock_ch", out_ch, 1);
        chk("t6_unlock_data", out_data, 64'h11);

        // 6b: asynchronous reset mid-burst
        out_ready = 1'b0;
        tick();
        set_in(0, 1'b1, 64'hB8, 1'b0);
        tick();
        tick();
        in_valid = '0;
        #2 rst = 1'b0;
        #1;
        chk("t6_arst_valid", out_valid, 0);
        chk("t6_arst_cnt", ch_count, 0);
        chk("t6_arst_data", out_data, 0);
        rst = 1'b1;
        #1;
        set_in(2, 1'b1, 64'h22, 1'b1);
        out_ready = 1'b1;
        tick();
        in_valid = '0;
        tick();
        chk("t6_arst_unlock_ch", out_ch, 2);
        chk("t6_arst_unlock_data", out_data, 64'h22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coh_chan_arb_buf.md
Name: coh_chan_arb_buf

Overview:
- Parametrised N-channel coherence message buffer and arbiter. Each channel carries one packed message bundle (req/rsp/fwd/DMA); generalises the fixed per-channel message bundles.
- Buffers each input channel in its own FIFO and merges the channels onto one output port (NoC plane or LLC input).
- Arbitration is round-robin or fixed-priority. Multi-beat DMA bursts lock the arbiter to one channel.
- Sits between L2/LLC/DMA channel producers and a shared NoC plane or LLC input.

Parameters:
N_CH, 3, number of input channels (>=2)
MSG_W, 64, packed message width in bits (coh_msg, addr, line, ids as packed by the producer)
DEPTH, 4, entries per channel FIFO (>=2, any integer)
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority with lowest index winning
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)
CH_W, $clog2(N_CH), channel index width (derived)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all FIFOs, output register, lock and pointer
in_valid  input  N_CH  per-channel message valid
in_ready  output  N_CH  per-channel accept
in_data  input  N_CH*MSG_W  per-channel message; channel i at [i*MSG_W +: MSG_W]
in_last  input  N_CH  1 = last beat of a message/burst; 0 = more beats follow (lock)
out_valid  output  1  output message valid (registered)
out_ready  input  1  downstream accept
out_data  output  MSG_W  output message (registered)
out_last  output  1  last flag of output beat
out_ch  output  CH_W  source channel of output beat
ch_count  output  N_CH*CNT_W  per-channel FIFO occupancy

Behaviour:
- Reset (rst=0, async):
  - All FIFOs are empty and ch_count = 0.
  - out_valid = 0, out_data = 0, out_last = 0, out_ch = 0.
  - RR pointer = 0, lock = 0.
  - in_ready = all 1 once rst is released.
  - Reset mid-burst discards all buffered beats and clears the lock.
- Enqueue:
  - Channel i captures in_data and in_last on an edge where in_valid[i] & in_ready[i].
  - in_ready[i] = (count_i < DEPTH) & ~flush. It is independent of out_ready, so there is no full-FIFO pass-through.
  - Write and read pointers wrap from DEPTH-1 to 0.
  - Simultaneous enqueue and dequeue on the same channel leaves count unchanged.
- Output stage:
  - One register, loaded when (~out_valid | out_ready) and a grant exists.
  - Loading pops the granted FIFO head.
  - If no grant exists and out_ready=1, out_valid drops to 0.
  - While out_valid & ~out_ready, out_data, out_last and out_ch hold stable.
  - Latency: a beat accepted into an empty block at edge k shows out_valid=1 after edge k+1.
  - Sustained throughput is 1 beat/cycle.
- Arbitration (evaluated combinationally each cycle among channels with count>0):
  - lock=1: only lock_ch is eligible. If that FIFO is empty, no grant is issued (bubble); other channels wait.
  - lock=0, PRIO_MODE=0: grant the first non-empty channel scanning ptr, ptr+1, ..., wrapping mod N_CH.
  - lock=0, PRIO_MODE=1: grant the lowest non-empty index.
  - On a pop with last=0: lock<=1, lock_ch<=grant.
  - On a pop with last=1: lock<=0, and ptr<=(grant+1) mod N_CH when PRIO_MODE=0.
  - ptr does not advance on non-last beats.
- ch_count[i] is the registered occupancy: +1 on enqueue, -1 on pop, unchanged on both. It is never above DEPTH.
- flush=1 at an edge:
  - All FIFOs, out_valid, lock and ptr are cleared, as at reset.
  - in_ready is 0 during the flush cycle.
  - Enqueues and out_ready in that cycle are ignored.

Test Plan:
1. Reset, then ch1 sends one beat 0xA5 with last=1 at edge 1 -> out_valid=1 after edge 2, out_data=0xA5, out_ch=1, out_last=1; ch_count[1] goes 1 then 0.
2. RR, N_CH=3, all channels preloaded with 2 beats (last=1), out_ready=1 -> out_ch sequence 0,1,2,0,1,2, no bubbles, then out_valid=0.
3. Lock: ch0 sends beats with last=0,0,1 while ch2 holds 1 beat, out_ready=1 -> out_ch = 0,0,0,2. If ch0's second beat arrives 3 cycles late, out_valid=0 during the gap and ch2 is still not granted.
4. Full/backpressure, DEPTH=4: ch0 sends 6 beats with out_ready=0 -> 1 beat in the output register and 4 in the FIFO; in_ready[0]=0 and ch_count[0]=4. The held out_data is stable. Raising out_ready drains all beats in order.
5. PRIO_MODE=1, ch0 and ch2 continuously valid -> ch0 is granted every cycle and ch2 only when ch0's FIFO is empty.
6. flush asserted with 3 beats buffered and out_valid=1 -> next cycle out_valid=0, ch_count all 0, lock=0. Async rst asserted mid-burst -> same state immediately.
